// File: rtl/eth_tx_arb.sv
// Round-robin arbiter that shares one eth_tx application port between N_REQ packet sources.
// Optional idle-beat watchdog in DATA is enabled by defining ETH_TX_ARB_WDOG_EN.
module eth_tx_arb #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned KEEP_W      = DATA_W / 8,
  parameter int unsigned LEN_W       = $clog2(KEEP_W + 1),
  parameter int unsigned PKT_LEN_W   = 16,
  parameter int unsigned UDP_CS_W    = 16,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [N_REQ-1:0]              req_early_v_i,
  output logic [N_REQ-1:0]              req_ready_v_o,
  input  logic [N_REQ-1:0]              req_cancel_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]       req_data_i,
  input  logic [N_REQ*LEN_W-1:0]        req_len_i,
  input  logic [N_REQ*PKT_LEN_W-1:0]    req_pkt_len_i,
  input  logic [N_REQ*UDP_CS_W-1:0]     req_cs_i,
  output logic                          tx_early_v_o,
  input  logic                          tx_ready_v_i,
  output logic                          tx_cancel_o,
  output logic                          tx_valid_o,
  output logic [DATA_W-1:0]             tx_data_o,
  output logic [LEN_W-1:0]              tx_len_o,
  output logic [PKT_LEN_W-1:0]          tx_pkt_len_o,
  output logic [UDP_CS_W-1:0]           tx_cs_o,
`ifdef ETH_TX_ARB_WDOG_EN
  output logic                          wdog_err_o,
`endif
  output logic [N_REQ-1:0]              gnt_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = PKT_LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PKT_LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic [UDP_CS_W-1:0]  cs_q, cs_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;

  logic                 pick_found_c;
  logic [IDX_W-1:0]     pick_idx_c;
  logic                 g_early_c, g_cancel_c, g_valid_c, last_c;
  logic [DATA_W-1:0]    g_data_c;
  logic [LEN_W-1:0]     g_len_c;
  logic [CNT_W-1:0]     beat_sum_c;

`ifdef ETH_TX_ARB_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
  logic              wdog_hit_c;
  assign wdog_err_o = wdog_err_q;
`endif

  // Round-robin search starting just above the last served requester.
  always_comb begin
    int unsigned idx;
    logic [IDX_W-1:0] cand;
    idx          = 0;
    cand         = '0;
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IDX_W'(idx);
      if (!pick_found_c && req_early_v_i[cand]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = cand;
      end
    end
  end

  assign g_early_c  = req_early_v_i[gnt_idx_q];
  assign g_cancel_c = req_cancel_i[gnt_idx_q];
  assign g_valid_c  = req_valid_i[gnt_idx_q];
  assign g_data_c   = req_data_i[gnt_idx_q*DATA_W +: DATA_W];
  assign g_len_c    = req_len_i[gnt_idx_q*LEN_W +: LEN_W];
  assign beat_sum_c = byte_cnt_q + CNT_W'(g_len_c);
  assign last_c     = beat_sum_c >= {1'b0, pkt_len_q};

  assign gnt_o        = gnt_q;
  assign tx_pkt_len_o = (state_q != ST_IDLE) ? pkt_len_q : '0;
  assign tx_cs_o      = (state_q != ST_IDLE) ? cs_q : '0;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gnt_idx_d     = gnt_idx_q;
    rr_ptr_d      = rr_ptr_q;
    pkt_len_d     = pkt_len_q;
    cs_d          = cs_q;
    byte_cnt_d    = byte_cnt_q;
    req_ready_v_o = '0;
    tx_early_v_o  = 1'b0;
    tx_cancel_o   = 1'b0;
    tx_valid_o    = 1'b0;
    tx_data_o     = '0;
    tx_len_o      = '0;
`ifdef ETH_TX_ARB_WDOG_EN
    wdog_cnt_d    = '0;
    wdog_err_d    = wdog_err_q;
    wdog_hit_c    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          gnt_idx_d = pick_idx_c;
          gnt_d     = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_c;
          pkt_len_d = req_pkt_len_i[pick_idx_c*PKT_LEN_W +: PKT_LEN_W];
          cs_d      = req_cs_i[pick_idx_c*UDP_CS_W +: UDP_CS_W];
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        tx_early_v_o = 1'b1;
        if (g_cancel_c || !g_early_c) begin
          tx_cancel_o = g_cancel_c;
          state_d     = ST_IDLE;
          gnt_d       = '0;
          rr_ptr_d    = gnt_idx_q;
        end else if (tx_ready_v_i) begin
          req_ready_v_o = gnt_q;
          byte_cnt_d    = '0;
          if (pkt_len_q == '0) begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            rr_ptr_d = gnt_idx_q;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        tx_valid_o = g_valid_c;
        if (g_valid_c) begin
          tx_data_o = g_data_c;
          tx_len_o  = g_len_c;
        end
`ifdef ETH_TX_ARB_WDOG_EN
        wdog_hit_c = !g_valid_c && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
        wdog_cnt_d = g_valid_c ? '0 : wdog_cnt_q + WDOG_W'(1);
`endif
        // Cancel outranks a coinciding last beat.
        if (g_cancel_c) begin
          tx_cancel_o = 1'b1;
          state_d     = ST_IDLE;
          gnt_d       = '0;
          rr_ptr_d    = gnt_idx_q;
        end else if (g_valid_c) begin
          byte_cnt_d = beat_sum_c;
          if (last_c) begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            rr_ptr_d = gnt_idx_q;
          end
`ifdef ETH_TX_ARB_WDOG_EN
        end else if (wdog_hit_c) begin
          tx_cancel_o = 1'b1;
          wdog_err_d  = 1'b1;
          state_d     = ST_IDLE;
          gnt_d       = '0;
          rr_ptr_d    = gnt_idx_q;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= IDX_W'(N_REQ - 1);
      pkt_len_q  <= '0;
      cs_q       <= '0;
      byte_cnt_q <= '0;
`ifdef ETH_TX_ARB_WDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_len_q  <= pkt_len_d;
      cs_q       <= cs_d;
      byte_cnt_q <= byte_cnt_d;
`ifdef ETH_TX_ARB_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

endmodule
